// File: rtl/bcd_timer_ctrl_if.sv
// Control/status bundle for the BCD down-counting timer.
// The master drives the run controls and the preset; the slave returns the count and status.
interface bcd_timer_ctrl_if;
    logic       start;
    logic       pause;
    logic       abort;
    logic [3:0] preset_tens;
    logic [3:0] preset_ones;
    logic [3:0] q_tens;
    logic [3:0] q_ones;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, pause, abort, preset_tens, preset_ones,
        input  q_tens, q_ones, busy, done, err
    );

    modport slave (
        input  start, pause, abort, preset_tens, preset_ones,
        output q_tens, q_ones, busy, done, err
    );
endinterface

// File: rtl/bcd_timer_ctrl.sv
// Two-digit BCD down-counter timer with a prescaler and an IDLE/RUN/PAUSE/DONE control FSM.
// All outputs come straight from flops; clear is an asynchronous active-high reset.
module bcd_timer_ctrl #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic              clk,
    input  logic              clear,
    bcd_timer_ctrl_if.slave   bus
);
    localparam int unsigned PRE_W    = 8;
    localparam int unsigned DIGIT_W  = 4;
    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [DIGIT_W-1:0] NINE     = DIGIT_W'(9);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t               state, state_nx;
    logic [DIGIT_W-1:0]   tens, tens_nx;
    logic [DIGIT_W-1:0]   ones, ones_nx;
    logic [PRE_W-1:0]     pre, pre_nx;
    logic                 err, err_nx;
    logic                 busy, done;
    logic                 preset_ok_c;
    logic                 preset_zero_c;

    assign preset_ok_c   = (bus.preset_tens <= NINE) && (bus.preset_ones <= NINE);
    assign preset_zero_c = (bus.preset_tens == '0) && (bus.preset_ones == '0);

    // Next-state and next-datapath logic; every register holds unless told otherwise.
    always_comb begin
        state_nx = state;
        tens_nx  = tens;
        ones_nx  = ones;
        pre_nx   = pre;
        err_nx   = err;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (!preset_ok_c) begin
                        err_nx = 1'b1;
                    end else begin
                        err_nx   = 1'b0;
                        tens_nx  = bus.preset_tens;
                        ones_nx  = bus.preset_ones;
                        pre_nx   = '0;
                        state_nx = preset_zero_c ? DONE : RUN;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    tens_nx  = '0;
                    ones_nx  = '0;
                    pre_nx   = '0;
                    state_nx = IDLE;
                end else if (bus.pause) begin
                    state_nx = PAUSE;
                end else if (pre == PRE_LAST) begin
                    pre_nx = '0;
                    if (ones != '0) begin
                        ones_nx = ones - DIGIT_W'(1);
                    end else begin
                        ones_nx = NINE;
                        tens_nx = tens - DIGIT_W'(1);
                    end
                    // Reaching 00 finishes the run on this same edge.
                    if ((tens == '0) && (ones == DIGIT_W'(1))) begin
                        state_nx = DONE;
                    end
                end else begin
                    pre_nx = pre + PRE_W'(1);
                end
            end
            PAUSE: begin
                if (bus.abort) begin
                    tens_nx  = '0;
                    ones_nx  = '0;
                    pre_nx   = '0;
                    state_nx = IDLE;
                end else if (!bus.pause) begin
                    state_nx = RUN;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and datapath registers; busy/done are registered from the next state.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= IDLE;
            tens  <= '0;
            ones  <= '0;
            pre   <= '0;
            err   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            tens  <= tens_nx;
            ones  <= ones_nx;
            pre   <= pre_nx;
            err   <= err_nx;
            busy  <= (state_nx == RUN) || (state_nx == PAUSE);
            done  <= (state_nx == DONE);
        end
    end

    assign bus.q_tens = tens;
    assign bus.q_ones = ones;
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.err    = err;
endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench for bcd_timer_ctrl: directed vector table, corner-case sequences,
// and random stimulus compared every cycle against an integer-valued timer model.
module tb_bcd_timer_ctrl;
    localparam int unsigned P = 4;

    logic clk;
    logic clear;
    bcd_timer_ctrl_if bus();

    bcd_timer_ctrl #(.PRESCALE(P)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the count is a plain integer 0..99, phase counts clocks since last step.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_mode = M_IDLE;
    int m_val  = 0;
    int m_ph   = 0;
    int m_err  = 0;

    typedef struct {
        logic       start;
        logic       pause;
        logic       abort;
        logic [3:0] pt;
        logic [3:0] po;
        int         e_tens;
        int         e_ones;
        int         e_busy;
        int         e_done;
        int         e_err;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input logic s, input logic pa, input logic ab,
                                input logic [3:0] pt, input logic [3:0] po,
                                input int et, input int eo, input int eb, input int ed, input int ee);
        vec_t v;
        v.start = s;  v.pause = pa; v.abort = ab; v.pt = pt; v.po = po;
        v.e_tens = et; v.e_ones = eo; v.e_busy = eb; v.e_done = ed; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = M_IDLE; m_val = 0; m_ph = 0; m_err = 0;
    endfunction

    function automatic void model_edge(input logic s, input logic pa, input logic ab,
                                       input logic [3:0] pt, input logic [3:0] po);
        case (m_mode)
            M_IDLE: if (s) begin
                if (int'(pt) > 9 || int'(po) > 9) m_err = 1;
                else begin
                    m_err = 0;
                    m_val = int'(pt) * 10 + int'(po);
                    m_ph  = 0;
                    m_mode = (m_val == 0) ? M_DONE : M_RUN;
                end
            end
            M_RUN: begin
                if (ab) begin m_mode = M_IDLE; m_val = 0; end
                else if (pa) m_mode = M_PAUSE;
                else begin
                    m_ph++;
                    if (m_ph == int'(P)) begin
                        m_ph = 0;
                        m_val--;
                        if (m_val == 0) m_mode = M_DONE;
                    end
                end
            end
            M_PAUSE: begin
                if (ab) begin m_mode = M_IDLE; m_val = 0; end
                else if (!pa) m_mode = M_RUN;
            end
            default: m_mode = M_IDLE;
        endcase
    endfunction

    task automatic check_model();
        chk("q_tens", int'(bus.q_tens), m_val / 10);
        chk("q_ones", int'(bus.q_ones), m_val % 10);
        chk("busy", int'(bus.busy), (m_mode == M_RUN || m_mode == M_PAUSE) ? 1 : 0);
        chk("done", int'(bus.done), (m_mode == M_DONE) ? 1 : 0);
        chk("err", int'(bus.err), m_err);
    endtask

    // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
    task automatic cycle(input logic s, input logic pa, input logic ab,
                         input logic [3:0] pt, input logic [3:0] po);
        bus.start = s; bus.pause = pa; bus.abort = ab;
        bus.preset_tens = pt; bus.preset_ones = po;
        @(posedge clk);
        model_edge(s, pa, ab, pt, po);
        #1;
        check_model();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_mode != M_IDLE && n < 500) begin
            cycle(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
            n++;
        end
        chk("drain_timeout", (m_mode == M_IDLE) ? 1 : 0, 1);
    endtask

    // Asynchronous clear between edges; outputs must be zero before the next edge.
    task automatic async_clear();
        #2;
        clear = 1'b1;
        #1;
        model_reset();
        chk("clr_q_tens", int'(bus.q_tens), 0);
        chk("clr_q_ones", int'(bus.q_ones), 0);
        chk("clr_busy", int'(bus.busy), 0);
        chk("clr_done", int'(bus.done), 0);
        chk("clr_err", int'(bus.err), 0);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        int busy_cnt, done_cnt, done_edge;
        logic s, pa, ab;
        logic [3:0] pt, po;

        bus.start = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0;
        bus.preset_tens = 4'd0; bus.preset_ones = 4'd0;
        clear = 1'b1;
        #12;
        chk("rst_q_tens", int'(bus.q_tens), 0);
        chk("rst_q_ones", int'(bus.q_ones), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err", int'(bus.err), 0);
        clear = 1'b0;
        model_reset();

        // Directed vector table: zero preset, invalid presets, idle pause/abort, ignored start.
        vecs[0] = mk(1'b1, 1'b0, 1'b0, 4'd0,  4'd0,  0, 0, 0, 1, 0);
        vecs[1] = mk(1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  0, 0, 0, 0, 0);
        vecs[2] = mk(1'b1, 1'b0, 1'b0, 4'hA,  4'd0,  0, 0, 0, 0, 1);
        vecs[3] = mk(1'b0, 1'b1, 1'b1, 4'd0,  4'd0,  0, 0, 0, 0, 1);
        vecs[4] = mk(1'b1, 1'b0, 1'b0, 4'd1,  4'hF,  0, 0, 0, 0, 1);
        vecs[5] = mk(1'b1, 1'b0, 1'b0, 4'd0,  4'd3,  0, 3, 1, 0, 0);
        vecs[6] = mk(1'b1, 1'b0, 1'b0, 4'd9,  4'd9,  0, 3, 1, 0, 0);
        vecs[7] = mk(1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  0, 3, 1, 0, 0);
        vecs[8] = mk(1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  0, 3, 1, 0, 0);
        vecs[9] = mk(1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  0, 2, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].start, vecs[i].pause, vecs[i].abort, vecs[i].pt, vecs[i].po);
            chk($sformatf("vec%0d_tens", i), int'(bus.q_tens), vecs[i].e_tens);
            chk($sformatf("vec%0d_ones", i), int'(bus.q_ones), vecs[i].e_ones);
            chk($sformatf("vec%0d_busy", i), int'(bus.busy), vecs[i].e_busy);
            chk($sformatf("vec%0d_done", i), int'(bus.done), vecs[i].e_done);
            chk($sformatf("vec%0d_err", i), int'(bus.err), vecs[i].e_err);
        end
        drain();

        // Preset 12: 48 busy cycles, single done pulse exactly at edge 48.
        cycle(1'b1, 1'b0, 1'b0, 4'd1, 4'd2);
        busy_cnt = int'(bus.busy); done_cnt = 0; done_edge = -1;
        for (int i = 1; i <= 50; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
            busy_cnt += int'(bus.busy);
            if (bus.done) begin done_cnt++; done_edge = i; end
        end
        chk("p12_busy_cycles", busy_cnt, 48);
        chk("p12_done_edge", done_edge, 48);
        chk("p12_done_count", done_cnt, 1);

        // Preset 07, pause at q=05 with prescaler at 2; step lands 2 edges after release.
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 4'd7);
        idle_cycles(10);
        chk("pz_q_before", int'(bus.q_ones), 5);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        chk("pz_q_held", int'(bus.q_ones), 5);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        idle_cycles(1);
        chk("pz_no_step_yet", int'(bus.q_ones), 5);
        idle_cycles(1);
        chk("pz_step_after_2", int'(bus.q_ones), 4);
        drain();

        // Abort during PAUSE.
        cycle(1'b1, 1'b0, 1'b0, 4'd2, 4'd5);
        idle_cycles(3);
        cycle(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        cycle(1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
        chk("abort_pause_busy", int'(bus.busy), 0);
        idle_cycles(2);

        // Abort together with start in RUN: start ignored, no done pulse.
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 4'd5);
        idle_cycles(2);
        cycle(1'b1, 1'b0, 1'b1, 4'd9, 4'd9);
        chk("abort_run_q", int'(bus.q_ones), 0);
        idle_cycles(2);

        // Asynchronous clear mid-run at q=37, then a normal run.
        cycle(1'b1, 1'b0, 1'b0, 4'd3, 4'd7);
        idle_cycles(2);
        chk("clr_pre_q", int'(bus.q_tens) * 10 + int'(bus.q_ones), 37);
        async_clear();
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 4'd2);
        drain();

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            s  = ($urandom % 6) == 0;
            pa = ($urandom % 5) == 0;
            ab = ($urandom % 40) == 0;
            pt = (($urandom % 10) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 2));
            po = (($urandom % 12) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            cycle(s, pa, ab, pt, po);
            if (($urandom % 400) == 0) async_clear();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bcd_timer_ctrl.md
BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

Interface
REQ-001 Parameter PRESCALE, default 4: clk cycles per count step; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 clear  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to load the preset and begin counting; sampled on the rising edge.
REQ-005 pause  input  1  level; holds the count while high.
REQ-006 abort  input  1  level; cancels the run.
REQ-007 preset_tens  input  4  BCD tens digit of the start value.
REQ-008 preset_ones  input  4  BCD ones digit of the start value.
REQ-009 q_tens  output  4  current BCD tens digit.
REQ-010 q_ones  output  4  current BCD ones digit.
REQ-011 busy  output  1  high in RUN or PAUSE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 err  output  1  sticky flag for an invalid BCD preset.

Function
REQ-014 The block SHALL be a Moore FSM with states IDLE, RUN, PAUSE and DONE, plus an 8-bit prescaler and a 2-digit BCD down-counter.
REQ-015 IDLE + start + both digits <= 9 + preset != 00: on that edge, load q from the preset, zero the prescaler, clear err, and go to RUN.
REQ-016 IDLE + start + valid preset == 00: load 00, clear err, go to DONE.
REQ-017 IDLE + start + either digit > 9: set err=1, stay in IDLE, leave q unchanged.
REQ-018 In RUN the prescaler SHALL count 0..PRESCALE-1 and wrap to 0; the wrap edge is a step edge.
REQ-019 Step rule: if q_ones != 0, decrement q_ones; if q_ones == 0, set q_ones to 9 and decrement q_tens; q SHALL never hold a non-BCD value.
REQ-020 A step that produces 00 SHALL move the FSM to DONE on the same edge.
REQ-021 RUN priority, highest first: abort, then pause, then step.
- abort: go to IDLE with q=00 and no done pulse.
- pause: go to PAUSE; no step and no prescaler advance on that edge.
REQ-022 PAUSE SHALL hold q and the prescaler value.
- pause=0: return to RUN, with the prescaler resuming from its held value.
- abort=1: go to IDLE with q=00 (abort wins over pause).
REQ-023 DONE SHALL last exactly one cycle, then go to IDLE; q holds 00.
REQ-024 done SHALL be 1 only in DONE; busy SHALL be 1 only in RUN or PAUSE.
REQ-025 start SHALL be ignored in RUN, PAUSE and DONE.
REQ-026 pause or abort asserted in IDLE SHALL have no effect.
REQ-027 Latency: start sampled at edge 0 with value N (decimal 1..99, PRESCALE=P).
- Steps occur at edges P, 2P, ..., N*P when no pause occurs.
- done is high from edge N*P to edge N*P+1.
- busy falls at edge N*P.
REQ-028 err SHALL stay at 1 until the next accepted valid start or clear.

Reset
REQ-029 clear=1 SHALL immediately, without waiting for a clk edge, force:
- state to IDLE
- q_tens and q_ones to 0
- prescaler to 0
- busy, done and err to 0
REQ-030 clear SHALL override every other input in every state, including mid-RUN and mid-PAUSE.
REQ-031 After clear falls, the first rising clk edge SHALL evaluate the IDLE transitions normally.

Verification
REQ-032 PRESCALE=4, preset 1/2, start pulse -> q steps 12,11,10,09,...,01,00 every 4 cycles; done high for exactly 1 cycle starting 48 edges after start; busy high for 48 cycles.
REQ-033 Preset 0/0, start -> DONE on the next edge, done=1 for one cycle, busy never 1, q=00.
REQ-034 Preset tens=4'hA, start -> err=1, busy=0, q unchanged; then a valid preset 0/3 start -> err=0 and the run proceeds.
REQ-035 PRESCALE=4, preset 0/7, pause held 10 cycles when q=05 and the prescaler is at 2 -> q stays 05; after release, the next step occurs 2 cycles later.
REQ-036 Abort during PAUSE, and separately abort with start on the same edge in RUN -> IDLE, q=00, busy=0, no done pulse, start ignored.
REQ-037 clear pulsed asynchronously mid-RUN at q=37 -> q=00, busy=0, done=0 and err=0 before the next clk edge; a subsequent start works normally.
